pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline stage that replaces the fixed stall-only inter-stage registers between CPU pipeline stages, for example memory-to-writeback. It carries an arbitrary-width payload through a DEPTH-entry circular buffer using a valid/ready handshake, so upstream stages keep issuing while the downstream stage stalls. It also provides a one-cycle flush for branch and exception squash. All outputs are driven from registered state; there is no combinational path from out_ready to in_ready.

## Interface
- DATA_W, 32, payload width in bits (1..256); a stage bundles pc, alu_out, reg dest, write enable, mem rdata and result into one vector.
- DEPTH, 2, number of buffer entries; must be a power of two, 2..8.
- RESET_VAL, 0, DATA_W-bit value loaded into every storage entry on reset.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards every stored entry and any push in the same cycle.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; equals (count != DEPTH).
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  head entry is valid; equals (count != 0).
- out_ready  input  1  downstream consumes the head this cycle; low is the downstream stall.
- out_data  output  DATA_W  head entry, mem[rd_ptr].
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

## Operation
- Storage is mem[0..DEPTH-1]. Pointers wr_ptr and rd_ptr are each $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. count is kept as a separate register.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- On push: write mem[wr_ptr] <= in_data, then wr_ptr <= wr_ptr+1.
- On pop: rd_ptr <= rd_ptr+1.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, including at count==DEPTH-1 and count==1.
  - neither: unchanged.
- Full (count==DEPTH): in_ready=0, so in_valid is ignored. A pop in the same cycle does not enable a push; in_ready depends only on registered count.
- Empty (count==0): out_valid=0, so out_ready is ignored. out_data shows mem[rd_ptr], which is stale or RESET_VAL; consumers must qualify it with out_valid.
- Flush: next cycle count=0 and wr_ptr=rd_ptr=0. Memory contents are untouched. Flush overrides push and pop in the same cycle.
- Reset priority: rst > flush > push/pop. On reset:
  - every mem entry <= RESET_VAL;
  - wr_ptr = rd_ptr = 0, count = 0;
  - after the reset edge: out_valid=0, in_ready=1, out_data=RESET_VAL, count=0.
- Reset or flush asserted mid-stream drops every pending entry. No entry is ever emitted after the cycle in which flush was sampled.
- No overflow or underflow is possible; an assertion in the bench checks count never exceeds DEPTH.
- With DEPTH=2 and out_ready tied to ~stall, throughput and data order match a classic stall register. Data order is strictly FIFO.

## Timing
- Push-to-output latency: 1 cycle. in_data sampled at edge N appears on out_data/out_valid after edge N when the buffer was empty.
- Steady state: 1 transfer per cycle when out_ready stays high.
- Backpressure: after out_ready drops, the stage absorbs up to DEPTH further pushes before in_ready falls. in_ready rises in the cycle after the first pop from full.
- Flush: takes effect at the sampling edge. out_valid=0 and in_ready=1 in the next cycle.
- All outputs change only at the rising edge of clk.

## Test plan
- Reset with DATA_W=32, RESET_VAL=32'hDEAD_BEEF; hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_data=32'hDEAD_BEEF after reset.
- Streaming, DEPTH=2: push 1,2,3,4 on consecutive cycles with out_ready=1 -> out_data 1,2,3,4 on the following four cycles; count stays 1; in_ready stays 1.
- Backpressure, DEPTH=4: out_ready=0, push 10,11,12,13,14 -> count reaches 4 and in_ready=0, 14 is not accepted. Then out_ready=1 for 4 cycles -> outputs 10,11,12,13 in order.
- Simultaneous push/pop at full, DEPTH=2: holding 5,6 with in_valid=1 (data 7) and out_ready=1 -> 5 pops, 7 is not taken that cycle, count=1, in_ready=1. The next cycle 7 is pushed while 6 pops.
- Flush: holding 20,21,22 with push 23 and flush=1 in the same cycle -> next cycle count=0, out_valid=0. Then push 30 -> out_data=30 one cycle later; 20..23 never appear.
- Pointer wrap, DEPTH=8: 20 push/pop cycles with random out_ready stalls -> output sequence equals input sequence, count matches the scoreboard every cycle.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: handshake bundle between pipeline stages and a pipe_stage_buf.
//   flush                squash everything stored plus any same-cycle push
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data head payload
//   count                current buffer occupancy, 0..DEPTH
//   master = stage side, slave = buffer side
interface pipe_stage_buf_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int CW = $clog2(DEPTH + 1);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry circular-buffer pipeline stage with flush.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pipe_stage_buf_if.slave: flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count
// in_ready and out_valid come from the registered count only, so there is no
// combinational path from out_ready to in_ready.
module pipe_stage_buf #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    assign bus.in_ready  = count_q != CW'(DEPTH);
    assign bus.out_valid = count_q != '0;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.count     = count_q;
    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;
    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = bus.flush ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = bus.flush ? '0 : pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = bus.flush        ? '0 :
                   (push && !pop)   ? count_q + 1'b1 :
                   (pop && !push)   ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    // Flush leaves storage alone; only reset reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed self-checking bench for pipe_stage_buf at DEPTH 2, 4 and 8.
module tb_pipe_stage_buf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(32), .DEPTH(2)) d2 ();
    pipe_stage_buf_if #(.DATA_W(32), .DEPTH(4)) d4 ();
    pipe_stage_buf_if #(.DATA_W(32), .DEPTH(8)) d8 ();

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .RESET_VAL(32'hDEAD_BEEF)) u_d2 (.clk(clk), .rst(rst), .bus(d2.slave));
    pipe_stage_buf #(.DATA_W(32), .DEPTH(4)) u_d4 (.clk(clk), .rst(rst), .bus(d4.slave));
    pipe_stage_buf #(.DATA_W(32), .DEPTH(8)) u_d8 (.clk(clk), .rst(rst), .bus(d8.slave));

    assert property (@(posedge clk) d2.count <= 2);
    assert property (@(posedge clk) d4.count <= 4);
    assert property (@(posedge clk) d8.count <= 8);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d2.in_valid = 1'b1;
        d2.in_data  = 32'd99;
        step();
        step();
        checks++; if (d2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", d2.out_valid); end
        checks++; if (d2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", d2.in_ready); end
        checks++; if (d2.count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", d2.count); end
        checks++; if (d2.out_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reset_out_data: got %h want deadbeef", d2.out_data); end
        rst = 1'b0;
        d2.in_valid = 1'b0;
        step();
        checks++; if (d2.count !== 2'd0) begin errors++; $display("FAIL reset_release_count: got %0d want 0", d2.count); end
    endtask

    task automatic test_stream();
        d2.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d2.in_valid = 1'b1;
            d2.in_data  = i;
            step();
            checks++; if (d2.out_valid !== 1'b1 || d2.out_data !== 32'(i)) begin errors++; $display("FAIL stream_data[%0d]: got v=%b %0d want v=1 %0d", i, d2.out_valid, d2.out_data, i); end
            checks++; if (d2.count !== 2'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, d2.count); end
            checks++; if (d2.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, d2.in_ready); end
        end
        d2.in_valid = 1'b0;
        step();
        checks++; if (d2.count !== 2'd0 || d2.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got count=%0d v=%b want 0 0", d2.count, d2.out_valid); end
    endtask

    task automatic test_backpressure();
        d4.out_ready = 1'b0;
        for (int i = 10; i <= 14; i++) begin
            d4.in_valid = 1'b1;
            d4.in_data  = i;
            step();
        end
        d4.in_valid = 1'b0;
        checks++; if (d4.count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d want 4", d4.count); end
        checks++; if (d4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b want 0", d4.in_ready); end
        d4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (d4.out_valid !== 1'b1 || d4.out_data !== 32'(10 + k)) begin errors++; $display("FAIL bp_order[%0d]: got v=%b %0d want v=1 %0d", k, d4.out_valid, d4.out_data, 10 + k); end
            step();
            if (k == 0) begin
                checks++; if (d4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after_pop: got %b want 1", d4.in_ready); end
            end
        end
        checks++; if (d4.count !== 3'd0 || d4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got count=%0d v=%b want 0 0 (14 must not be stored)", d4.count, d4.out_valid); end
        d4.out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        d2.out_ready = 1'b0;
        d2.in_valid  = 1'b1;
        d2.in_data   = 32'd5;
        step();
        d2.in_data   = 32'd6;
        step();
        checks++; if (d2.count !== 2'd2 || d2.in_ready !== 1'b0) begin errors++; $display("FAIL full_fill: got count=%0d rdy=%b want 2 0", d2.count, d2.in_ready); end
        d2.in_data   = 32'd7;
        d2.out_ready = 1'b1;
        checks++; if (d2.out_data !== 32'd5) begin errors++; $display("FAIL full_head: got %0d want 5", d2.out_data); end
        step();
        checks++; if (d2.count !== 2'd1 || d2.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_only: got count=%0d rdy=%b want 1 1", d2.count, d2.in_ready); end
        checks++; if (d2.out_data !== 32'd6) begin errors++; $display("FAIL full_next_head: got %0d want 6", d2.out_data); end
        step();
        checks++; if (d2.count !== 2'd1 || d2.out_data !== 32'd7) begin errors++; $display("FAIL full_push_pop: got count=%0d data=%0d want 1 7", d2.count, d2.out_data); end
        d2.in_valid = 1'b0;
        step();
        checks++; if (d2.count !== 2'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", d2.count); end
    endtask

    task automatic test_flush();
        d4.out_ready = 1'b0;
        for (int i = 20; i <= 22; i++) begin
            d4.in_valid = 1'b1;
            d4.in_data  = i;
            step();
        end
        checks++; if (d4.count !== 3'd3) begin errors++; $display("FAIL flush_fill: got %0d want 3", d4.count); end
        d4.in_data = 32'd23;
        d4.flush   = 1'b1;
        step();
        d4.flush = 1'b0;
        checks++; if (d4.count !== 3'd0 || d4.out_valid !== 1'b0 || d4.in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got count=%0d v=%b rdy=%b want 0 0 1", d4.count, d4.out_valid, d4.in_ready); end
        d4.in_data = 32'd30;
        step();
        d4.in_valid = 1'b0;
        checks++; if (d4.out_valid !== 1'b1 || d4.out_data !== 32'd30 || d4.count !== 3'd1) begin errors++; $display("FAIL flush_repush: got v=%b data=%0d count=%0d want 1 30 1", d4.out_valid, d4.out_data, d4.count); end
        d4.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (d4.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale[%0d]: got v=%b data=%0d want v=0", k, d4.out_valid, d4.out_data); end
        end
        d4.out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        logic [31:0] nxt = 32'd100;
        bit          pu, po;
        for (int c = 0; c < 20; c++) begin
            d8.in_valid  = 1'b1;
            d8.in_data   = nxt;
            d8.out_ready = ($urandom_range(0, 3) != 0);
            pu = (q.size() < 8);
            po = d8.out_ready && (q.size() > 0);
            checks++; if (d8.in_ready !== pu) begin errors++; $display("FAIL wrap_in_ready[%0d]: got %b want %b", c, d8.in_ready, pu); end
            if (po) begin
                checks++; if (d8.out_data !== q[0]) begin errors++; $display("FAIL wrap_data[%0d]: got %0d want %0d", c, d8.out_data, q[0]); end
                void'(q.pop_front());
            end
            if (pu) begin
                q.push_back(nxt);
                nxt++;
            end
            step();
            checks++; if (d8.count !== 4'(q.size())) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", c, d8.count, q.size()); end
        end
        d8.in_valid  = 1'b0;
        d8.out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            checks++; if (d8.out_valid !== 1'b1 || d8.out_data !== q[0]) begin errors++; $display("FAIL wrap_drain[%0d]: got v=%b %0d want v=1 %0d", n, d8.out_valid, d8.out_data, q[0]); end
            void'(q.pop_front());
            step();
        end
        checks++; if (d8.count !== 4'd0 || q.size() != 0) begin errors++; $display("FAIL wrap_empty: got count=%0d left=%0d want 0 0", d8.count, q.size()); end
    endtask

    initial begin
        d2.flush = 1'b0; d2.in_valid = 1'b0; d2.in_data = '0; d2.out_ready = 1'b0;
        d4.flush = 1'b0; d4.in_valid = 1'b0; d4.in_data = '0; d4.out_ready = 1'b0;
        d8.flush = 1'b0; d8.in_valid = 1'b0; d8.in_data = '0; d8.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_flush();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
